// File: rtl/vcm_i2c_target_if.sv
// Bus-side signal bundle for the VCM I2C target.
//   SCL_IN, SDA_IN : bus line levels seen by the target (asynchronous)
//   SDA_OE         : 1 = target pulls SDA low, 0 = released
//   RD_DATA16      : value returned on 2-byte reads, MSB byte first
//   VCM_DATA       : last completed write, {pointer, data}
//   WR_STROBE      : one-cycle pulse when VCM_DATA updates
//   BUSY           : addressed transaction in progress
//   ADDR_MATCH     : current transaction's address matched
interface vcm_i2c_target_if;
    logic        SCL_IN;
    logic        SDA_IN;
    logic        SDA_OE;
    logic [15:0] RD_DATA16;
    logic [15:0] VCM_DATA;
    logic        WR_STROBE;
    logic        BUSY;
    logic        ADDR_MATCH;

    // Bus master / environment side
    modport master (
        output SCL_IN, SDA_IN, RD_DATA16,
        input  SDA_OE, VCM_DATA, WR_STROBE, BUSY, ADDR_MATCH
    );

    // Target side
    modport slave (
        input  SCL_IN, SDA_IN, RD_DATA16,
        output SDA_OE, VCM_DATA, WR_STROBE, BUSY, ADDR_MATCH
    );
endinterface

// File: rtl/vcm_i2c_target.sv
// I2C target for the VCM write link: decodes address/pointer/data writes into
// a 16-bit {pointer, data} command and answers 2-byte reads of RD_DATA16.
//   CLK_400K : sampling clock (SCL phases must each span >= 4 cycles)
//   RESET_N  : asynchronous active-low reset
//   bus      : vcm_i2c_target_if.slave (SCL/SDA in, SDA_OE, command/status outputs)
module vcm_i2c_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h0C,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK_400K,
    input  logic                  RESET_N,
    vcm_i2c_target_if.slave       bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] BITS_PER_BYTE = CNT_W'(8);
    localparam logic [CNT_W-1:0] LAST_BIT_IDX  = CNT_W'(7);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_RD_BYTE,
        ST_RD_MACK,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]       shift_q, shift_d;      // bits received so far in the current byte
    logic [7:0]       ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic [14:0]      tx_q, tx_d;            // read bits not yet driven, next bit at [14]
    logic             rd_lo_q, rd_lo_d;      // low read byte is in flight
    logic             mack_q, mack_d;        // master ACKed, drive next byte on SCL fall
    logic             sda_oe_q, sda_oe_d;
    logic [15:0]      vcm_data_q, vcm_data_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic             busy_q, busy_d;
    logic             addr_match_q, addr_match_d;

    logic       scl_s, sda_s;
    logic       start_ev, stop_ev, scl_rise, scl_fall;
    logic [7:0] rx_byte;

    // Synchronizer chains plus one registered copy for edge detection
    always_comb begin
        scl_sync_d    = scl_sync_q;
        sda_sync_d    = sda_sync_q;
        scl_sync_d[0] = bus.SCL_IN;
        sda_sync_d[0] = bus.SDA_IN;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            scl_sync_d[i] = scl_sync_q[i-1];
            sda_sync_d[i] = sda_sync_q[i-1];
        end
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Bus event decode
    always_comb begin
        scl_s    = scl_sync_q[SYNC_STAGES-1];
        sda_s    = sda_sync_q[SYNC_STAGES-1];
        start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        scl_rise = scl_s & ~scl_prev_q;
        scl_fall = ~scl_s & scl_prev_q;
        rx_byte  = {shift_q, sda_s};
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        rw_d         = rw_q;
        tx_d         = tx_q;
        rd_lo_d      = rd_lo_q;
        mack_d       = mack_q;
        sda_oe_d     = sda_oe_q;
        vcm_data_d   = vcm_data_q;
        wr_strobe_d  = 1'b0;
        busy_d       = busy_q;
        addr_match_d = addr_match_q;

        if (start_ev) begin
            state_d      = ST_ADDR;
            bit_cnt_d    = '0;
            shift_d      = '0;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            mack_d       = 1'b0;
            rd_lo_d      = 1'b0;
        end else if (stop_ev) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            mack_d       = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;

                // Receive-byte states share shifting; the 8th bit is acted on per state
                ST_ADDR, ST_PTR, ST_DATA: begin
                    if (scl_rise && (bit_cnt_q < BITS_PER_BYTE)) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT_IDX) begin
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    addr_match_d = 1'b1;
                                    busy_d       = 1'b1;
                                    rw_d         = rx_byte[0];
                                end else begin
                                    state_d   = ST_IGNORE;
                                    bit_cnt_d = '0;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d = rx_byte;
                            end else begin
                                vcm_data_d  = {ptr_q, rx_byte};
                                wr_strobe_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            state_d = ST_ADDR_ACK;
                        end else if (state_q == ST_PTR) begin
                            state_d = ST_PTR_ACK;
                        end else begin
                            state_d = ST_DATA_ACK;
                        end
                    end
                end

                // Release ACK on the 9th fall; reads put bit 15 out on that same edge
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            tx_d     = bus.RD_DATA16[14:0];
                            sda_oe_d = ~bus.RD_DATA16[15];
                            rd_lo_d  = 1'b0;
                            state_d  = ST_RD_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_PTR;
                        end
                    end
                end

                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end
                end

                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_IGNORE;
                    end
                end

                ST_RD_BYTE: begin
                    if (scl_rise && (bit_cnt_q < BITS_PER_BYTE)) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            mack_d    = 1'b0;
                            state_d   = ST_RD_MACK;
                        end else begin
                            sda_oe_d = ~tx_q[14];
                            tx_d     = {tx_q[13:0], 1'b0};
                        end
                    end
                end

                // Master ACK after the high byte continues with the low byte
                ST_RD_MACK: begin
                    if (scl_rise) begin
                        if (sda_s || rd_lo_q) begin
                            state_d = ST_IGNORE;
                        end else begin
                            mack_d = 1'b1;
                        end
                    end else if (scl_fall && mack_q) begin
                        sda_oe_d  = ~tx_q[14];
                        tx_d      = {tx_q[13:0], 1'b0};
                        rd_lo_d   = 1'b1;
                        mack_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_RD_BYTE;
                    end
                end

                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State register; sync chains reset to the idle-bus level
    always_ff @(posedge CLK_400K or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ptr_q        <= '0;
            rw_q         <= 1'b0;
            tx_q         <= '0;
            rd_lo_q      <= 1'b0;
            mack_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
            vcm_data_q   <= '0;
            wr_strobe_q  <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            tx_q         <= tx_d;
            rd_lo_q      <= rd_lo_d;
            mack_q       <= mack_d;
            sda_oe_q     <= sda_oe_d;
            vcm_data_q   <= vcm_data_d;
            wr_strobe_q  <= wr_strobe_d;
            busy_q       <= busy_d;
            addr_match_q <= addr_match_d;
        end
    end

    assign bus.SDA_OE     = sda_oe_q;
    assign bus.VCM_DATA   = vcm_data_q;
    assign bus.WR_STROBE  = wr_strobe_q;
    assign bus.BUSY       = busy_q;
    assign bus.ADDR_MATCH = addr_match_q;

endmodule

// File: tb/tb_vcm_i2c_target.sv
// Self-checking bench for vcm_i2c_target: a bit-level I2C master drives the bus,
// and a transaction-level model predicts ACKs, read bits and the VCM command.
module tb_vcm_i2c_target;

    localparam int H = 8;   // SCL half period in CLK_400K cycles

    logic        clk;
    logic        rst_n;
    logic        m_scl;
    logic        m_sda;
    logic [15:0] rd_val;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state
    logic [15:0] exp_vcm;
    int          exp_strobes;

    // Output monitors, sampled on the inactive edge
    int   strobe_cnt  = 0;
    int   strobe_wide = 0;
    int   oe_cnt      = 0;
    int   match_cnt   = 0;
    logic strobe_prev = 1'b0;

    vcm_i2c_target_if bus_if ();

    assign bus_if.SCL_IN    = m_scl;
    assign bus_if.SDA_IN    = m_sda & ~bus_if.SDA_OE;   // open-drain wired-AND
    assign bus_if.RD_DATA16 = rd_val;

    vcm_i2c_target #(.DEV_ADDR(7'h0C), .SYNC_STAGES(2)) dut (
        .CLK_400K (clk),
        .RESET_N  (rst_n),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.WR_STROBE) strobe_cnt <= strobe_cnt + 1;
        if (bus_if.WR_STROBE && strobe_prev) strobe_wide <= strobe_wide + 1;
        strobe_prev <= bus_if.WR_STROBE;
        if (bus_if.SDA_OE) oe_cnt <= oe_cnt + 1;
        if (bus_if.ADDR_MATCH) match_cnt <= match_cnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Byte idx 0 is the address; a matched write ACKs address, pointer and data only.
    function automatic logic model_wr_ack(input logic matched, input int idx);
        return matched && (idx <= 2);
    endfunction

    // ---------------- bus master primitives ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        cyc(H/2); m_sda = b;
        cyc(H/2); m_scl = 1'b1;
        cyc(H/2); s = bus_if.SDA_IN;
        cyc(H/2); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        cyc(H/2); m_sda = 1'b1;
        cyc(H/2); m_scl = 1'b1;
        cyc(H);   m_sda = 1'b0;
        cyc(H);   m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(H/2); m_sda = 1'b0;
        cyc(H/2); m_scl = 1'b1;
        cyc(H);   m_sda = 1'b1;
        cyc(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clk_bit(~mack, s);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rd_val = '0;
        exp_vcm = '0; exp_strobes = 0;
        cyc(4);
        rst_n = 1'b1;
        cyc(4);
        n_checks++; if (bus_if.SDA_OE !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", bus_if.SDA_OE); end
        n_checks++; if (bus_if.VCM_DATA !== 16'h0000) begin n_fail++; $display("FAIL reset_vcm: got %h expected 0000", bus_if.VCM_DATA); end
        n_checks++; if (bus_if.WR_STROBE !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", bus_if.WR_STROBE); end
        n_checks++; if (bus_if.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_if.BUSY); end
        n_checks++; if (bus_if.ADDR_MATCH !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b expected 0", bus_if.ADDR_MATCH); end
    endtask

    task automatic test_write_basic();
        logic a0, a1, a2;
        int   s0, w0;
        s0 = strobe_cnt; w0 = strobe_wide;
        i2c_start();
        write_byte(8'h18, a0);
        n_checks++; if (bus_if.BUSY !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", bus_if.BUSY); end
        n_checks++; if (bus_if.ADDR_MATCH !== 1'b1) begin n_fail++; $display("FAIL wr_match: got %b expected 1", bus_if.ADDR_MATCH); end
        write_byte(8'h3A, a1);
        write_byte(8'hC5, a2);
        i2c_stop();
        exp_vcm = {8'h3A, 8'hC5}; exp_strobes = 1;
        n_checks++; if ({a0, a1, a2} !== {model_wr_ack(1'b1, 0), model_wr_ack(1'b1, 1), model_wr_ack(1'b1, 2)}) begin n_fail++; $display("FAIL wr_acks: got %b expected 111", {a0, a1, a2}); end
        n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL wr_vcm: got %h expected %h", bus_if.VCM_DATA, exp_vcm); end
        n_checks++; if (strobe_cnt - s0 !== exp_strobes) begin n_fail++; $display("FAIL wr_strobe_count: got %0d expected %0d", strobe_cnt - s0, exp_strobes); end
        n_checks++; if (strobe_wide - w0 !== 0) begin n_fail++; $display("FAIL wr_strobe_width: got %0d multi-cycle expected 0", strobe_wide - w0); end
        n_checks++; if (bus_if.BUSY !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop: got %b expected 0", bus_if.BUSY); end
    endtask

    task automatic test_addr_mismatch();
        logic [6:0] a;
        logic       ack;
        int         oe0, m0, nacks;
        a = 7'h10;
        for (int k = 0; k < 3; k++) begin
            oe0 = oe_cnt; m0 = match_cnt; nacks = 0;
            i2c_start();
            write_byte({a, 1'b0}, ack);
            if (ack === model_wr_ack(1'b0, 0)) nacks++;
            for (int i = 1; i <= 2; i++) begin
                write_byte(8'($urandom), ack);
                if (ack === model_wr_ack(1'b0, i)) nacks++;
            end
            i2c_stop();
            n_checks++; if (nacks !== 3) begin n_fail++; $display("FAIL nm_nacks(%h): got %0d correct expected 3", a, nacks); end
            n_checks++; if (oe_cnt - oe0 !== 0) begin n_fail++; $display("FAIL nm_sda_oe(%h): got %0d cycles expected 0", a, oe_cnt - oe0); end
            n_checks++; if (match_cnt - m0 !== 0) begin n_fail++; $display("FAIL nm_match(%h): got %0d cycles expected 0", a, match_cnt - m0); end
            n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL nm_vcm(%h): got %h expected %h", a, bus_if.VCM_DATA, exp_vcm); end
            do a = 7'($urandom); while (a == 7'h0C);
        end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] hi, lo;
        rd_val = 16'hA55A;
        for (int k = 0; k < 3; k++) begin
            i2c_start();
            write_byte(8'h19, ack);
            read_byte(1'b1, hi);
            read_byte(1'b0, lo);
            cyc(H);
            n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack: got %b expected 1", ack); end
            n_checks++; if ({hi, lo} !== rd_val) begin n_fail++; $display("FAIL rd_data: got %h expected %h", {hi, lo}, rd_val); end
            n_checks++; if (bus_if.SDA_OE !== 1'b0) begin n_fail++; $display("FAIL rd_release: got %b expected 0", bus_if.SDA_OE); end
            i2c_stop();
            n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL rd_vcm: got %h expected %h", bus_if.VCM_DATA, exp_vcm); end
            rd_val = 16'($urandom);
        end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2, a3, a4;
        int   s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h18, a0);
        write_byte(8'h11, a1);
        i2c_start();
        write_byte(8'h18, a2);
        write_byte(8'h22, a3);
        write_byte(8'h33, a4);
        i2c_stop();
        exp_vcm = 16'h2233;
        n_checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin n_fail++; $display("FAIL rs_acks: got %b expected 11111", {a0, a1, a2, a3, a4}); end
        n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL rs_vcm: got %h expected %h", bus_if.VCM_DATA, exp_vcm); end
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL rs_strobes: got %0d expected 1", strobe_cnt - s0); end
    endtask

    task automatic test_extra_bytes();
        logic [7:0] bytes [4];
        logic       ack;
        int         good, s0;
        bytes[0] = 8'h18; bytes[1] = 8'h44; bytes[2] = 8'h55; bytes[3] = 8'h66;
        s0 = strobe_cnt; good = 0;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], ack);
            if (ack === model_wr_ack(1'b1, i)) good++;
        end
        i2c_stop();
        exp_vcm = {bytes[1], bytes[2]};
        n_checks++; if (good !== 4) begin n_fail++; $display("FAIL extra_acks: got %0d correct expected 4", good); end
        n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL extra_vcm: got %h expected %h", bus_if.VCM_DATA, exp_vcm); end
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL extra_strobes: got %0d expected 1", strobe_cnt - s0); end
    endtask

    task automatic test_reset_mid_ack();
        logic       ack, s;
        logic [7:0] p;
        p = 8'($urandom);
        i2c_start();
        write_byte(8'h18, ack);
        for (int i = 7; i >= 0; i--) clk_bit(p[i], s);
        cyc(H/2); m_sda = 1'b1;
        cyc(H/2); m_scl = 1'b1;
        cyc(H/2);
        n_checks++; if (bus_if.SDA_OE !== 1'b1) begin n_fail++; $display("FAIL rm_ptr_ack: got %b expected 1", bus_if.SDA_OE); end
        rst_n = 1'b0;
        #1;
        exp_vcm = '0;
        n_checks++; if (bus_if.SDA_OE !== 1'b0) begin n_fail++; $display("FAIL rm_async_release: got %b expected 0", bus_if.SDA_OE); end
        n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL rm_vcm_reset: got %h expected %h", bus_if.VCM_DATA, exp_vcm); end
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        i2c_start();
        write_byte(8'h18, ack);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack);
        i2c_stop();
        exp_vcm = 16'h0102;
        n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL rm_fresh_write: got %h expected %h", bus_if.VCM_DATA, exp_vcm); end
    endtask

    task automatic test_random();
        logic [7:0] bytes [5];
        logic [7:0] hi, lo;
        logic       ack, matched, mack;
        int         nb, s0, bad;
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                matched = ($urandom_range(0, 3) != 0);
                nb = int'($urandom_range(0, 4));
                if (matched) bytes[0] = 8'h18;
                else begin
                    do bytes[0] = {7'($urandom), 1'b0}; while (bytes[0][7:1] == 7'h0C);
                end
                for (int i = 1; i < 5; i++) bytes[i] = 8'($urandom);
                s0 = strobe_cnt; bad = 0;
                i2c_start();
                for (int i = 0; i <= nb; i++) begin
                    write_byte(bytes[i], ack);
                    if (ack !== model_wr_ack(matched, i)) bad++;
                end
                i2c_stop();
                if (matched && nb >= 2) exp_vcm = {bytes[1], bytes[2]};
                n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rnd_wr_acks(t=%0d): got %0d wrong expected 0", t, bad); end
                n_checks++; if (bus_if.VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL rnd_wr_vcm(t=%0d): got %h expected %h", t, bus_if.VCM_DATA, exp_vcm); end
                n_checks++; if (strobe_cnt - s0 !== ((matched && nb >= 2) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_wr_strobes(t=%0d): got %0d expected %0d", t, strobe_cnt - s0, (matched && nb >= 2) ? 1 : 0); end
            end else begin
                rd_val = 16'($urandom);
                mack = 1'($urandom);
                i2c_start();
                write_byte(8'h19, ack);
                read_byte(mack, hi);
                lo = rd_val[7:0];
                if (mack) read_byte(1'b0, lo);
                cyc(H);
                n_checks++; if ({ack, hi, lo} !== {1'b1, rd_val}) begin n_fail++; $display("FAIL rnd_rd(t=%0d): got %b_%h%h expected 1_%h", t, ack, hi, lo, rd_val); end
                n_checks++; if (bus_if.SDA_OE !== 1'b0) begin n_fail++; $display("FAIL rnd_rd_release(t=%0d): got %b expected 0", t, bus_if.SDA_OE); end
                i2c_stop();
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_addr_mismatch();
        test_read();
        test_repeated_start();
        test_extra_bytes();
        test_reset_mid_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vcm_i2c_target.md
Name: vcm_i2c_target

Overview:
- I2C target (slave) responder for the VCM write link; the far end of the bus driven by the VCM I2C master.
- Decodes START/address/pointer/data sequences on SCL/SDA and presents the received {pointer, data} word as a 16-bit VCM command.
- Also answers 2-byte reads from a 16-bit status input.
- Used as the bench/loopback target for the master and as an on-chip VCM register model.

Parameters:
- DEV_ADDR, 7'h0C, 7-bit target address. Bus byte is 8'h18 for write and 8'h19 for read.
- SYNC_STAGES, 2, input synchronizer depth on SCL and SDA.

Ports:
- CLK_400K  input  1  sampling clock. Bus SCL high and low phases must each be >= 4 CLK_400K cycles.
- RESET_N  input  1  asynchronous, active-low reset.
- SCL_IN  input  1  bus SCL level (asynchronous).
- SDA_IN  input  1  bus SDA level (asynchronous).
- SDA_OE  output  1  1 = pull SDA low; 0 = release (open-drain, external pull-up).
- RD_DATA16  input  16  value returned on reads, MSB byte first.
- VCM_DATA  output  16  last completed write, {pointer, data}.
- WR_STROBE  output  1  one-cycle pulse when VCM_DATA updates.
- BUSY  output  1  1 from an addressed START until STOP or a return to IDLE.
- ADDR_MATCH  output  1  1 while the current transaction's address matched.

Behaviour:
- Reset (asynchronous): SDA_OE=0, VCM_DATA=16'h0000, WR_STROBE=0, BUSY=0, ADDR_MATCH=0, state=IDLE, bit count=0, shift register=0. Reset mid-transaction releases SDA immediately.
- Synchronization:
  - SCL and SDA each pass through SYNC_STAGES flops, plus one registered copy for edge detection.
  - Event detection latency is SYNC_STAGES+1 cycles after the pin change.
- Bus events (priority order):
  - START: SDA falling while SCL high. Fires from any state, including a repeated START. Goes to ADDR, bit count=0, SDA_OE=0.
  - STOP: SDA rising while SCL high. Goes to IDLE from any state, SDA_OE=0, BUSY=0, ADDR_MATCH=0.
  - SCL rising: sample SDA into the shift register MSB-first and increment the bit count.
  - SCL falling: the only point where SDA_OE may change.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, DATA, DATA_ACK, RD_BYTE, RD_MACK, IGNORE.
- ADDR:
  - After the 8th rising edge, compare shift[7:1] with DEV_ADDR.
  - Match: ADDR_MATCH=1, BUSY=1. On the next SCL falling edge, SDA_OE=1 and go to ADDR_ACK.
  - Mismatch: go to IGNORE with SDA_OE=0 (NACK).
- ADDR_ACK:
  - Hold SDA_OE=1 through the 9th SCL pulse; release on its falling edge.
  - R/W=0: go to PTR.
  - R/W=1: latch RD_DATA16, drive bit 15 on that same falling edge, go to RD_BYTE.
- PTR then PTR_ACK: latch the pointer byte, ACK it the same way, go to DATA.
- DATA then DATA_ACK:
  - ACK the data byte.
  - On the 8th rising edge of DATA: VCM_DATA <= {pointer, data} and WR_STROBE=1 for exactly one cycle.
  - After the ACK, go to IGNORE.
  - Any further bytes before STOP are NACKed (SDA released) and ignored.
- RD_BYTE:
  - On each SCL falling edge, SDA_OE = ~current bit (a 0 bit drives low).
  - After 8 bits, release SDA and go to RD_MACK.
- RD_MACK:
  - Sample the master's ACK on the 9th rising edge.
  - ACK (SDA=0) after the high byte: drive bits 7..0 of the latched value.
  - NACK, or completion of the low byte: go to IGNORE.
- IGNORE: SDA_OE=0, wait for START or STOP.
- Aborts:
  - A START or STOP before DATA completes leaves VCM_DATA unchanged; no partial writes.
  - A write cut after the pointer byte produces no strobe.
  - A START or STOP while SDA_OE=1 releases SDA in the same cycle.
- Bit count is 4 bits and saturates only via state changes; it is never left wrapping within a byte.

Test Plan:
- Write 0x18, 0x3A, 0xC5, STOP -> three ACKs (SDA low on the 9th clocks); VCM_DATA=16'h3AC5; WR_STROBE high exactly 1 cycle; BUSY returns to 0 after STOP.
- Address 0x20 (write) followed by 2 bytes -> SDA_OE never asserted; VCM_DATA unchanged; ADDR_MATCH stays 0.
- RD_DATA16=16'hA55A, read 0x19, master ACK, then NACK -> SDA bit stream 10100101 then 01011010; SDA released after the final bit; state IGNORE.
- Write 0x18, 0x11, then repeated START, then 0x18, 0x22, 0x33, STOP -> only the second write lands: VCM_DATA=16'h2233, one strobe.
- Write 0x18, 0x44, 0x55, 0x66 -> fourth byte NACKed; VCM_DATA=16'h4455 with a single strobe.
- RESET_N low during the pointer-byte ACK (SDA_OE=1) -> SDA_OE=0 asynchronously, VCM_DATA=0; after release, a fresh write 0x18, 0x01, 0x02 gives 16'h0102.
